// File: rtl/memory_port_arbiter_pkg.sv
// memory_port_arbiter_pkg: shared types and constants for the memory port arbiter
package memory_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESPOND} state_t;
    typedef enum logic {OWNER_FETCH, OWNER_DATA} owner_t;
    localparam logic [3:0] BYTE_ENABLE_WORD = 4'b1111;
    typedef struct packed {
        logic        write;
        logic [31:0] address;
        logic [31:0] write_value;
        logic [3:0]  byte_enable;
    } payload_t;
    function automatic logic [31:0] word_align(input logic [31:0] address);
        return address & 32'hFFFF_FFFC;
    endfunction
endpackage

// File: rtl/memory_port_arbiter_watchdog_counter.sv
// watchdog_counter: counts transaction cycles and flags when the timeout budget is used up
// Ports: clock/reset (async, active-high); clear zeroes the count; count_enable advances it;
// expired is high from the last allowed cycle onward.
module watchdog_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_enable,
    output logic expired
);
    localparam int COUNTER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [COUNTER_WIDTH-1:0] count;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (count_enable) count <= count + COUNTER_WIDTH'(1);
    end
    // Expiry is flagged on the last permitted cycle so the exit edge lands exactly on the budget.
    assign expired = count >= COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory port between fetch and load/store, round-robin, with watchdog
// Ports: clock/reset (async, active-high); fetch_* and data_* requester channels (request/grant,
// valid/data/error responses); memory_* request/ready/valid handshake toward memory.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_request,
    input  logic [31:0] fetch_address,
    output logic        fetch_grant,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    output logic        fetch_error,
    input  logic        data_request,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_write_value,
    input  logic [3:0]  data_byte_enable,
    output logic        data_grant,
    output logic        data_valid,
    output logic [31:0] data_read_value,
    output logic        data_error,
    output logic        memory_request,
    output logic        memory_write,
    output logic [31:0] memory_address,
    output logic [31:0] memory_write_value,
    output logic [3:0]  memory_byte_enable,
    input  logic        memory_ready,
    input  logic        memory_valid,
    input  logic [31:0] memory_read_value
);
    state_t   state, state_next;
    owner_t   owner, owner_next, last_owner, last_owner_next;
    payload_t payload, payload_next;
    logic misaligned, misaligned_next, request_next, expired, fetch_win;
    logic respond, respond_error, fetch_grant_next, data_grant_next;
    logic fetch_valid_next, data_valid_next;
    logic [31:0] fetch_data_next, data_read_value_next;

    watchdog_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) watchdog (
        .clock(clock),
        .reset(reset),
        .clear(state == IDLE && state_next == ISSUE),
        .count_enable(state == ISSUE || state == WAIT_RESP),
        .expired(expired)
    );

    // Fetch wins when alone, or on a tie when data owned the previous transaction.
    assign fetch_win = fetch_request && (!data_request || last_owner == OWNER_DATA);

    always_comb begin
        state_next = state;
        owner_next = owner;
        last_owner_next = last_owner;
        payload_next = payload;
        misaligned_next = misaligned;
        request_next = memory_request;
        respond = 1'b0;
        respond_error = 1'b0;
        fetch_grant_next = 1'b0;
        data_grant_next = 1'b0;
        case (state)
            IDLE: if (fetch_request || data_request) begin
                owner_next = fetch_win ? OWNER_FETCH : OWNER_DATA;
                last_owner_next = owner_next;
                fetch_grant_next = fetch_win;
                data_grant_next = !fetch_win;
                misaligned_next = fetch_win && fetch_address[1:0] != 2'b00;
                payload_next = fetch_win
                    ? payload_t'{1'b0, word_align(fetch_address), 32'h0, BYTE_ENABLE_WORD}
                    : payload_t'{data_write, word_align(data_address), data_write_value, data_byte_enable};
                // A misaligned fetch is answered locally and never reaches memory.
                request_next = !misaligned_next;
                state_next = ISSUE;
            end
            ISSUE: begin
                // memory_valid only counts as the response once memory has accepted the request.
                respond = misaligned || (memory_ready && memory_valid) || expired;
                respond_error = misaligned || !(memory_ready && memory_valid);
                request_next = !respond && !memory_ready;
                state_next = respond ? RESPOND : memory_ready ? WAIT_RESP : ISSUE;
            end
            WAIT_RESP: begin
                respond = memory_valid || expired;
                respond_error = !memory_valid;
                state_next = respond ? RESPOND : WAIT_RESP;
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign fetch_valid_next = respond && owner == OWNER_FETCH;
    assign data_valid_next = respond && owner == OWNER_DATA;
    assign fetch_data_next = (fetch_valid_next && !respond_error) ? memory_read_value : 32'h0;
    assign data_read_value_next = (data_valid_next && !respond_error) ? memory_read_value : 32'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= OWNER_FETCH;
            last_owner <= OWNER_FETCH;
            payload <= '0;
            misaligned <= 1'b0;
            memory_request <= 1'b0;
            fetch_grant <= 1'b0;
            data_grant <= 1'b0;
            fetch_valid <= 1'b0;
            data_valid <= 1'b0;
            fetch_error <= 1'b0;
            data_error <= 1'b0;
            fetch_data <= '0;
            data_read_value <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            last_owner <= last_owner_next;
            payload <= payload_next;
            misaligned <= misaligned_next;
            memory_request <= request_next;
            fetch_grant <= fetch_grant_next;
            data_grant <= data_grant_next;
            fetch_valid <= fetch_valid_next;
            data_valid <= data_valid_next;
            fetch_error <= fetch_valid_next && respond_error;
            data_error <= data_valid_next && respond_error;
            fetch_data <= fetch_data_next;
            data_read_value <= data_read_value_next;
        end
    end

    assign memory_write = payload.write;
    assign memory_address = payload.address;
    assign memory_write_value = payload.write_value;
    assign memory_byte_enable = payload.byte_enable;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed scenarios checked every cycle against a transaction-timeline model
module tb_memory_port_arbiter;
    localparam int T = 8;
    localparam int N = 128;
    localparam int END_CYCLE = 75;

    logic clock = 1'b0, reset = 1'b1;
    logic fetch_request = 1'b0, data_request = 1'b0, data_write = 1'b0;
    logic [31:0] fetch_address = '0, data_address = '0, data_write_value = '0;
    logic [3:0] data_byte_enable = '0;
    logic memory_ready = 1'b0, memory_valid = 1'b0;
    logic [31:0] memory_read_value = '0;
    logic fetch_grant, fetch_valid, fetch_error, data_grant, data_valid, data_error;
    logic memory_request, memory_write;
    logic [31:0] fetch_data, data_read_value, memory_address, memory_write_value;
    logic [3:0] memory_byte_enable;

    memory_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset),
        .fetch_request(fetch_request), .fetch_address(fetch_address),
        .fetch_grant(fetch_grant), .fetch_valid(fetch_valid),
        .fetch_data(fetch_data), .fetch_error(fetch_error),
        .data_request(data_request), .data_write(data_write),
        .data_address(data_address), .data_write_value(data_write_value),
        .data_byte_enable(data_byte_enable), .data_grant(data_grant),
        .data_valid(data_valid), .data_read_value(data_read_value), .data_error(data_error),
        .memory_request(memory_request), .memory_write(memory_write),
        .memory_address(memory_address), .memory_write_value(memory_write_value),
        .memory_byte_enable(memory_byte_enable), .memory_ready(memory_ready),
        .memory_valid(memory_valid), .memory_read_value(memory_read_value)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic rst, f_req;
        logic [31:0] f_addr;
        logic d_req, d_write;
        logic [31:0] d_addr, d_wv;
        logic [3:0] d_be;
        logic m_ready, m_valid;
        logic [31:0] m_rdata;
    } stim_t;
    typedef struct packed {
        logic fg, dg, fv, fe, dv, de, mreq, mw, chk_wv;
        logic [31:0] fd, dd, ma, mwv;
        logic [3:0] mbe;
    } exp_t;
    typedef struct packed {
        logic fg, dg, fv, fe, dv, de, mreq, mw;
        logic [31:0] fd, dd, ma, mwv;
        logic [3:0] mbe;
    } obs_t;
    typedef struct {
        bit is_data, write;
        logic [31:0] addr, wv, rdata;
        logic [3:0] be;
        int arrival, k, vd;
    } txn_t;

    stim_t stim[N];
    exp_t ex[N];
    obs_t hist[N];
    txn_t fq[$], dq[$];
    int cyc = 0, compared = 0, mismatched = 0;

    task automatic chk32(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s cycle %0d got %h want %h", name, c, got, want);
        end
    endtask

    task automatic chk1(input string name, input int c, input logic got, input logic want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s cycle %0d got %b want %b", name, c, got, want);
        end
    endtask

    function automatic txn_t mk(input bit is_data, input bit write, input logic [31:0] addr,
                                input logic [31:0] wv, input logic [3:0] be, input int arrival,
                                input int k, input int vd, input logic [31:0] rdata);
        txn_t t;
        t.is_data = is_data; t.write = write; t.addr = addr; t.wv = wv; t.be = be;
        t.arrival = arrival; t.k = k; t.vd = vd; t.rdata = rdata;
        return t;
    endfunction

    // One granted transaction: k = ISSUE cycle on which memory is ready (0 = never),
    // vd = cycles from ready to valid. Writes expected outputs and memory stimulus.
    task automatic place(input int g, input txn_t t, output int resp);
        bit mis, err;
        int last;
        mis = !t.is_data && t.addr[1:0] != 2'b00;
        err = mis || t.k == 0;
        if (mis) resp = g + 1;
        else begin
            last = (t.k == 0) ? g + T - 1 : g + t.k - 1;
            for (int c = g; c <= last; c++) begin
                ex[c].mreq = 1'b1;
                ex[c].ma = t.addr & 32'hFFFF_FFFC;
                ex[c].mw = t.is_data && t.write;
                ex[c].mbe = t.is_data ? t.be : 4'hF;
                ex[c].chk_wv = t.is_data;
                ex[c].mwv = t.wv;
            end
            if (t.k == 0) resp = g + T;
            else begin
                stim[last].m_ready = 1'b1;
                stim[last + t.vd].m_valid = 1'b1;
                stim[last + t.vd].m_rdata = t.rdata;
                resp = last + t.vd + 1;
            end
        end
        if (t.is_data) begin
            ex[g].dg = 1'b1; ex[resp].dv = 1'b1; ex[resp].de = err; ex[resp].dd = err ? 32'h0 : t.rdata;
        end else begin
            ex[g].fg = 1'b1; ex[resp].fv = 1'b1; ex[resp].fe = err; ex[resp].fd = err ? 32'h0 : t.rdata;
        end
    endtask

    // Arbitration model: sample in the first idle cycle with a pending request; ties go to the
    // requester that did not own the previous transaction. Idle resumes the cycle after response.
    task automatic run_model(input int f0, input bit last_data_in, output int f_end);
        int free_c, fprev, dprev, fe, de, a, g, resp;
        bit fp, dp, take_data, last_data;
        txn_t t;
        free_c = f0; fprev = -100; dprev = -100; last_data = last_data_in;
        while (fq.size() != 0 || dq.size() != 0) begin
            fe = fq.size() != 0 ? (fq[0].arrival > fprev + 1 ? fq[0].arrival : fprev + 1) : 1 << 20;
            de = dq.size() != 0 ? (dq[0].arrival > dprev + 1 ? dq[0].arrival : dprev + 1) : 1 << 20;
            a = fe < de ? fe : de;
            a = a > free_c ? a : free_c;
            fp = fe <= a; dp = de <= a;
            take_data = dp && (!fp || !last_data);
            g = a + 1;
            if (take_data) begin
                t = dq.pop_front();
                for (int c = de; c < g; c++) begin
                    stim[c].d_req = 1'b1; stim[c].d_write = t.write; stim[c].d_addr = t.addr;
                    stim[c].d_wv = t.wv; stim[c].d_be = t.be;
                end
                dprev = g;
            end else begin
                t = fq.pop_front();
                for (int c = fe; c < g; c++) begin
                    stim[c].f_req = 1'b1; stim[c].f_addr = t.addr;
                end
                fprev = g;
            end
            place(g, t, resp);
            free_c = resp + 1;
            last_data = take_data;
        end
        f_end = free_c;
    endtask

    task automatic apply(input stim_t s);
        reset = s.rst; fetch_request = s.f_req; fetch_address = s.f_addr;
        data_request = s.d_req; data_write = s.d_write; data_address = s.d_addr;
        data_write_value = s.d_wv; data_byte_enable = s.d_be;
        memory_ready = s.m_ready; memory_valid = s.m_valid; memory_read_value = s.m_rdata;
    endtask

    always @(negedge clock) begin
        if (cyc < N) begin
            hist[cyc] = '{fetch_grant, data_grant, fetch_valid, fetch_error, data_valid, data_error,
                          memory_request, memory_write, fetch_data, data_read_value,
                          memory_address, memory_write_value, memory_byte_enable};
            chk1("fetch_grant", cyc, fetch_grant, ex[cyc].fg);
            chk1("data_grant", cyc, data_grant, ex[cyc].dg);
            chk1("fetch_valid", cyc, fetch_valid, ex[cyc].fv);
            chk1("fetch_error", cyc, fetch_error, ex[cyc].fe);
            chk1("data_valid", cyc, data_valid, ex[cyc].dv);
            chk1("data_error", cyc, data_error, ex[cyc].de);
            chk1("memory_request", cyc, memory_request, ex[cyc].mreq);
            if (ex[cyc].fv) chk32("fetch_data", cyc, fetch_data, ex[cyc].fd);
            if (ex[cyc].dv) chk32("data_read_value", cyc, data_read_value, ex[cyc].dd);
            if (ex[cyc].mreq) begin
                chk32("memory_address", cyc, memory_address, ex[cyc].ma);
                chk32("memory_byte_enable", cyc, 32'(memory_byte_enable), 32'(ex[cyc].mbe));
                chk1("memory_write", cyc, memory_write, ex[cyc].mw);
            end
            if (ex[cyc].chk_wv) chk32("memory_write_value", cyc, memory_write_value, ex[cyc].mwv);
        end
    end

    initial begin
        int f_end, scratch;
        for (int c = 0; c < N; c++) begin
            stim[c] = '0;
            ex[c] = '0;
            hist[c] = '0;
        end
        for (int c = 0; c < 5; c++) stim[c].rst = 1'b1;
        fq.push_back(mk(0, 0, 32'h100, 0, 4'hF, 5, 1, 2, 32'hDEADBEEF));
        fq.push_back(mk(0, 0, 32'h40, 0, 4'hF, 12, 2, 1, 32'h0F0F0F0F));
        fq.push_back(mk(0, 0, 32'h44, 0, 4'hF, 12, 1, 0, 32'h55AA55AA));
        fq.push_back(mk(0, 0, 32'h102, 0, 4'hF, 38, 1, 0, 32'h77777777));
        fq.push_back(mk(0, 0, 32'h400, 0, 4'hF, 52, 1, 1, 32'hCAFEF00D));
        dq.push_back(mk(1, 1, 32'h20, 32'h11223344, 4'hF, 12, 1, 0, 32'h99999999));
        dq.push_back(mk(1, 0, 32'h24, 32'h0, 4'hF, 12, 1, 1, 32'hA5A5A5A5));
        dq.push_back(mk(1, 1, 32'h203, 32'hAB000000, 4'b1000, 30, 3, 1, 32'h12345678));
        dq.push_back(mk(1, 0, 32'h300, 32'h0, 4'hF, 42, 0, 0, 32'h0));
        run_model(5, 1'b0, f_end);
        dq.push_back(mk(1, 0, 32'h500, 32'h0, 4'hF, 58, 1, 4, 32'hBAD0BAD0));
        run_model(f_end, 1'b0, scratch);
        // Reset lands in WAIT_RESP: the transaction is abandoned and its late valid arrives in IDLE.
        stim[61].rst = 1'b1;
        stim[62].rst = 1'b1;
        for (int c = 61; c <= scratch; c++) ex[c] = '0;
        dq.push_back(mk(1, 0, 32'h600, 32'h0, 4'hF, 64, 1, 0, 32'h66666666));
        fq.push_back(mk(0, 0, 32'h700, 0, 4'hF, 64, 1, 0, 32'h70707070));
        run_model(63, 1'b0, scratch);
        apply(stim[0]);
        while (cyc < END_CYCLE) begin
            @(posedge clock);
            cyc++;
            #1 apply(stim[cyc]);
        end
        @(negedge clock);
        #1;
        chk1("reset_quiet", 3, hist[3] != '0, 1'b0);
        chk1("s1_grant", 6, hist[6].fg, 1'b1);
        chk32("s1_address", 6, hist[6].ma, 32'h100);
        chk32("s1_enable", 6, 32'(hist[6].mbe), 32'hF);
        chk1("s1_request_drop", 7, hist[7].mreq, 1'b0);
        chk1("s1_valid", 9, hist[9].fv, 1'b1);
        chk32("s1_data", 9, hist[9].fd, 32'hDEADBEEF);
        chk1("s1_valid_pulse", 10, hist[10].fv, 1'b0);
        chk1("tie1_data", 13, hist[13].dg, 1'b1);
        chk1("tie1_write", 13, hist[13].mw, 1'b1);
        chk1("tie2_fetch", 16, hist[16].fg, 1'b1);
        chk1("tie3_data", 21, hist[21].dg, 1'b1);
        chk1("tie3_write", 21, hist[21].mw, 1'b0);
        chk32("store_address", 31, hist[31].ma, 32'h200);
        chk32("store_enable", 31, 32'(hist[31].mbe), 32'h8);
        chk1("store_valid", 35, hist[35].dv, 1'b1);
        chk1("misaligned_no_request", 39, hist[39].mreq, 1'b0);
        chk1("misaligned_valid", 40, hist[40].fv, 1'b1);
        chk1("misaligned_error", 40, hist[40].fe, 1'b1);
        chk32("misaligned_data", 40, hist[40].fd, 32'h0);
        chk1("timeout_request_last", 50, hist[50].mreq, 1'b1);
        chk1("timeout_request_drop", 51, hist[51].mreq, 1'b0);
        chk1("timeout_error", 51, hist[51].de, 1'b1);
        chk32("after_timeout_fetch", 55, hist[55].fd, 32'hCAFEF00D);
        chk1("reset_outputs_zero", 61, hist[61] != '0, 1'b0);
        chk1("stale_valid_ignored", 64, hist[64].dv, 1'b0);
        chk1("post_reset_tie_data", 65, hist[65].dg, 1'b1);
        chk1("post_reset_fetch", 68, hist[68].fg, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch and the load/store unit.
- Single outstanding transaction; round-robin between the two requesters when both are pending.
- Sequences a request/ready/valid memory handshake and routes each response back to its owner.
- A watchdog timeout returns an error response instead of hanging the core.

Parameters:
TIMEOUT_CYCLES, 256, max cycles from issue to response before error response; must be >=2
COUNTER_WIDTH, $clog2(TIMEOUT_CYCLES+1), watchdog counter width (derived, not overridden)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
fetch_request  input  1  fetch wants a word read; held until fetch_grant
fetch_address  input  32  fetch byte address
fetch_grant  output  1  one-cycle pulse: fetch request accepted
fetch_valid  output  1  one-cycle pulse: fetch response present
fetch_data  output  32  fetch read data, valid with fetch_valid
fetch_error  output  1  qualifies fetch_valid: misaligned or timeout
data_request  input  1  load/store wants access; held until data_grant
data_write  input  1  1=store, 0=load
data_address  input  32  load/store byte address
data_write_value  input  32  store data, already lane-aligned
data_byte_enable  input  4  store/load byte lanes
data_grant  output  1  one-cycle pulse: data request accepted
data_valid  output  1  one-cycle pulse: data response present
data_read_value  output  32  raw word to load unit, valid with data_valid
data_error  output  1  qualifies data_valid: timeout
memory_request  output  1  transaction request to memory
memory_write  output  1  write qualifier
memory_address  output  32  word-aligned address {addr[31:2],2'b00}
memory_write_value  output  32  write data
memory_byte_enable  output  4  byte lanes
memory_ready  input  1  memory accepts request this cycle
memory_valid  input  1  memory response present this cycle
memory_read_value  input  32  memory read data

Behaviour:
- Reset: all outputs 0; state IDLE; last_owner=FETCH, so data wins the first tie; counter 0.
- Reset is asynchronous. Mid-transaction reset abandons it with no response. A stale memory_valid after reset is ignored.
- All outputs are registered.
- States:
  - IDLE: arbiter picks an owner from the pending requests.
  - ISSUE: memory_request held high.
  - WAIT_RESP: waiting for memory_valid.
  - RESPOND: one-cycle response pulse.
- Arbitration (IDLE):
  - Only one request pending: that requester wins.
  - Both pending: the requester not equal to last_owner wins.
  - Winner's address, write, data and enables are latched. Its grant pulses the next cycle. last_owner is updated. Next state is ISSUE.
- Latency: memory_request first high in the cycle after the request is sampled, coincident with the grant pulse.
- Fetch transactions:
  - Force memory_write=0 and memory_byte_enable=4'b1111.
  - fetch_address[1:0]!=0: grant, then skip memory. Next cycle (RESPOND): fetch_valid=1, fetch_error=1, fetch_data=0. memory_request never asserts.
- ISSUE:
  - memory_request and all payload held stable until memory_ready=1 is sampled.
  - Then drop memory_request next cycle and go to WAIT_RESP.
- memory_valid in the same cycle as memory_ready is legal; it is treated as the response, with ISSUE going directly to RESPOND.
- WAIT_RESP:
  - On memory_valid, capture memory_read_value into the owner's data output and go to RESPOND.
  - Owner's valid pulses one cycle with error=0. The other requester's outputs stay 0.
- Watchdog:
  - Counter clears on entering ISSUE and increments each cycle in ISSUE or WAIT_RESP.
  - On reaching TIMEOUT_CYCLES: memory_request drops, and RESPOND delivers error=1 with data=0.
  - A later memory_valid from the dead transaction is ignored if it arrives while in IDLE. This is a documented limitation: memory must not respond after timeout.
- RESPOND: always returns to IDLE. Requests seen in RESPOND are not arbitrated until IDLE.
- Minimum occupancy per transaction is 4 cycles: IDLE, ISSUE, WAIT_RESP/RESPOND path, back to IDLE.
- Requests arriving outside IDLE are held by the requester (no drop). Grant is the only accept signal.
- memory_valid while no transaction is outstanding is ignored.

Decomposition:
- Package memory_port_arbiter_pkg:
  - state encoding (IDLE, ISSUE, WAIT_RESP, RESPOND)
  - owner constants OWNER_FETCH / OWNER_DATA
  - BYTE_ENABLE_WORD = 4'b1111
- Sub-module watchdog_counter, parameterised by TIMEOUT_CYCLES. Inputs: clear and count_enable. Output: expired.

Test Plan:
- Single fetch: fetch_request, address 0x100, ready on 1st ISSUE cycle, valid 2 cycles later with 0xDEADBEEF → fetch_grant one pulse; memory_address 0x100, enable 4'hF; fetch_valid one pulse, fetch_data 0xDEADBEEF, fetch_error 0.
- Simultaneous requests after reset, repeated three times with both held → grant order data, fetch, data; memory_write follows the data_write of the data owner.
- Store at 0x203 with byte_enable 4'b1000, value 0xAB000000 → memory_address 0x200, byte_enable 4'b1000, memory_write 1; data_valid after memory_valid.
- Misaligned fetch at 0x102 → fetch_valid=1, fetch_error=1, fetch_data=0 two cycles after the request is sampled; memory_request stays 0 throughout.
- TIMEOUT_CYCLES=8, memory_ready never asserted → memory_request high exactly 8 cycles, then data_valid=1, data_error=1; a subsequent fetch proceeds normally.
- Reset asserted during WAIT_RESP, then memory_valid after release → all outputs 0 immediately; no *_valid pulse; the next request is arbitrated as in the post-reset state (data wins the tie).
